// File: rtl/FetchUnitTypes.sv
// Shared fetch-unit types for the checkpointed return address stack.
// The types describe the default configuration; parametrised modules derive their own widths.
package FetchUnitTypes;

    localparam int RAS_ENTRY_NUM      = 16;
    localparam int RAS_FETCH_WIDTH    = 4;
    localparam int RAS_CKPT_ENTRY_NUM = 8;
    localparam int RAS_PC_WIDTH       = 32;
    localparam int RAS_INSN_BYTES     = 4;
    localparam int RAS_PTR_WIDTH      = $clog2(RAS_ENTRY_NUM);

    typedef logic [$clog2(RAS_CKPT_ENTRY_NUM)-1:0] RAS_CkptIndexPath;
    typedef logic [RAS_PTR_WIDTH-1:0]              RAS_PtrPath;
    typedef logic [RAS_PTR_WIDTH:0]                RAS_CountPath;

    typedef struct packed {
        RAS_PtrPath              ptr;
        logic [RAS_PC_WIDTH-1:0] top;
        RAS_CountPath            count;
    } RAS_CheckpointEntry;

endpackage

// File: rtl/ras_checkpoint_queue.sv
// Circular checkpoint buffer: allocate at tail, release at head, and rewind the tail
// on recovery so that every checkpoint younger than the restored one is discarded.
module ras_checkpoint_queue #(
    parameter int CKPT_NUM = 8,
    parameter int DATA_W   = 8,
    localparam int IW      = $clog2(CKPT_NUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_i,
    input  logic [DATA_W-1:0] alloc_data_i,
    input  logic              commit_i,
    input  logic              recover_i,
    input  logic [IW-1:0]     recover_id_i,
    output logic [IW-1:0]     tail_o,
    output logic [IW-1:0]     head_o,
    output logic [IW:0]       occ_o,
    output logic              full_o,
    output logic [DATA_W-1:0] recover_data_o
);

    logic [IW-1:0]     head_q, head_d;
    logic [IW-1:0]     tail_q, tail_d;
    logic [IW:0]       occ_q, occ_d;
    logic              release_s;
    logic [DATA_W-1:0] data_q [CKPT_NUM];

    // Pointer and occupancy next state; recovery overrides allocation and commit.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        occ_d     = occ_q;
        release_s = commit_i && (occ_q != '0);
        if (recover_i) begin
            tail_d = recover_id_i + IW'(1);
            occ_d  = {1'b0, recover_id_i - head_q} + (IW+1)'(1);
        end else begin
            if (alloc_i) begin
                tail_d = tail_q + IW'(1);
            end else begin
                tail_d = tail_q;
            end
            if (release_s) begin
                head_d = head_q + IW'(1);
            end else begin
                head_d = head_q;
            end
            case ({alloc_i, release_s})
                2'b10:   occ_d = occ_q + (IW+1)'(1);
                2'b01:   occ_d = occ_q - (IW+1)'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // Checkpoint payload storage, written at the tail on allocation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CKPT_NUM; i++) begin
                data_q[i] <= '0;
            end
        end else if (alloc_i && !recover_i) begin
            data_q[tail_q] <= alloc_data_i;
        end
    end

    assign tail_o         = tail_q;
    assign head_o         = head_q;
    assign occ_o          = occ_q;
    assign full_o         = (occ_q == (IW+1)'(CKPT_NUM));
    assign recover_data_o = data_q[recover_id_i];

endmodule

// File: rtl/ras_checkpointed_chk.sv
// Protocol checker: a recovery must target a checkpoint inside the live window.
module ras_checkpointed_chk #(
    parameter int IW = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          recover,
    input logic [IW-1:0] recover_id,
    input logic [IW-1:0] head,
    input logic [IW:0]   occ
);

    logic [IW-1:0] dist_s;
    assign dist_s = recover_id - head;

    a_recover_live: assert property (@(posedge clk) disable iff (!rst)
        recover |-> ((occ != '0) && ({1'b0, dist_s} < occ)))
        else $error("recoverId %0d outside live checkpoint window", recover_id);

endmodule

// File: rtl/ras_checkpointed.sv
// Speculative return address stack with per-op checkpoints and single-cycle repair
// (restore from a checkpoint, then optionally apply the corrected push or pop).
module ras_checkpointed
    import FetchUnitTypes::*;
#(
    parameter int ENTRY_NUM   = RAS_ENTRY_NUM,
    parameter int FETCH_WIDTH = RAS_FETCH_WIDTH,
    parameter int CKPT_NUM    = RAS_CKPT_ENTRY_NUM,
    parameter int PC_WIDTH    = RAS_PC_WIDTH,
    parameter int INSN_BYTES  = RAS_INSN_BYTES,
    localparam int PW         = $clog2(ENTRY_NUM),
    localparam int IW         = $clog2(CKPT_NUM),
    localparam int SW         = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetchValid,
    input  logic [PC_WIDTH-1:0]    groupPC,
    input  logic [FETCH_WIDTH-1:0] isPush,
    input  logic [FETCH_WIDTH-1:0] isPop,
    output logic                   popValid,
    output logic [PC_WIDTH-1:0]    popTarget,
    output logic [SW-1:0]          popSlot,
    output logic                   ckptFull,
    output logic [IW-1:0]          ckptId,
    input  logic                   commit,
    input  logic                   recover,
    input  logic [IW-1:0]          recoverId,
    input  logic                   recoverPush,
    input  logic [PC_WIDTH-1:0]    recoverPushPC,
    input  logic                   recoverPop
);

    localparam int CW = PW + 1;

    typedef struct packed {
        logic [PW-1:0]       ptr;
        logic [PC_WIDTH-1:0] top;
        logic [CW-1:0]       count;
    } ckpt_entry_t;

    localparam int CKPT_W = $bits(ckpt_entry_t);

    function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
        return (c == CW'(ENTRY_NUM)) ? c : c + CW'(1);
    endfunction

    function automatic logic [CW-1:0] cnt_dec(input logic [CW-1:0] c);
        return (c == '0) ? c : c - CW'(1);
    endfunction

    logic [PC_WIDTH-1:0] stack_q [ENTRY_NUM];
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic                op_found_s, op_push_s, accept_s;
    logic [SW-1:0]       op_slot_s;
    logic [PC_WIDTH-1:0] push_pc_s;

    logic                wr0_en_s, wr1_en_s;
    logic [PW-1:0]       wr0_idx_s, wr1_idx_s;
    logic [PC_WIDTH-1:0] wr0_data_s, wr1_data_s;

    ckpt_entry_t         save_s, rest_s;
    logic [CKPT_W-1:0]   rest_raw_s;
    logic [IW-1:0]       tail_s, head_s;
    logic [IW:0]         occ_s;
    logic                full_s;

    // Lowest slot carrying a call or return owns the group's single RAS op.
    always_comb begin
        op_found_s = 1'b0;
        op_push_s  = 1'b0;
        op_slot_s  = '0;
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (isPush[i] || isPop[i]) begin
                op_found_s = 1'b1;
                op_push_s  = isPush[i];
                op_slot_s  = SW'(i);
            end else begin
                op_found_s = op_found_s;
            end
        end
    end

    assign accept_s  = fetchValid && !recover && !full_s && op_found_s;
    assign push_pc_s = groupPC + (PC_WIDTH'(op_slot_s) + PC_WIDTH'(1)) * PC_WIDTH'(INSN_BYTES);
    assign save_s    = '{ptr: ptr_q, top: stack_q[ptr_q], count: cnt_q};
    assign rest_s    = ckpt_entry_t'(rest_raw_s);

    // Next stack state and combinational pop outputs.
    always_comb begin
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        wr0_en_s   = 1'b0;
        wr0_idx_s  = ptr_q;
        wr0_data_s = '0;
        wr1_en_s   = 1'b0;
        wr1_idx_s  = ptr_q;
        wr1_data_s = '0;
        popValid   = 1'b0;
        popTarget  = '0;
        popSlot    = '0;
        ckptId     = '0;
        if (recover) begin
            ptr_d      = rest_s.ptr;
            cnt_d      = rest_s.count;
            wr0_en_s   = 1'b1;
            wr0_idx_s  = rest_s.ptr;
            wr0_data_s = rest_s.top;
            if (recoverPush) begin
                ptr_d      = rest_s.ptr + PW'(1);
                cnt_d      = cnt_inc(rest_s.count);
                wr1_en_s   = 1'b1;
                wr1_idx_s  = rest_s.ptr + PW'(1);
                wr1_data_s = recoverPushPC;
            end else if (recoverPop) begin
                ptr_d = rest_s.ptr - PW'(1);
                cnt_d = cnt_dec(rest_s.count);
            end else begin
                ptr_d = rest_s.ptr;
            end
        end else if (accept_s) begin
            ckptId = tail_s;
            if (op_push_s) begin
                ptr_d      = ptr_q + PW'(1);
                cnt_d      = cnt_inc(cnt_q);
                wr1_en_s   = 1'b1;
                wr1_idx_s  = ptr_q + PW'(1);
                wr1_data_s = push_pc_s;
            end else if (cnt_q != '0) begin
                popValid  = 1'b1;
                popTarget = stack_q[ptr_q];
                popSlot   = op_slot_s;
                ptr_d     = ptr_q - PW'(1);
                cnt_d     = cnt_q - CW'(1);
            end else begin
                ptr_d = ptr_q;
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Stack storage; the two write ports never collide since ENTRY_NUM >= 2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            if (wr0_en_s) begin
                stack_q[wr0_idx_s] <= wr0_data_s;
            end
            if (wr1_en_s) begin
                stack_q[wr1_idx_s] <= wr1_data_s;
            end
        end
    end

    ras_checkpoint_queue #(
        .CKPT_NUM (CKPT_NUM),
        .DATA_W   (CKPT_W)
    ) u_ckpt_q (
        .clk            (clk),
        .rst            (rst),
        .alloc_i        (accept_s),
        .alloc_data_i   (save_s),
        .commit_i       (commit),
        .recover_i      (recover),
        .recover_id_i   (recoverId),
        .tail_o         (tail_s),
        .head_o         (head_s),
        .occ_o          (occ_s),
        .full_o         (full_s),
        .recover_data_o (rest_raw_s)
    );

    assign ckptFull = full_s;

    ras_checkpointed_chk #(
        .IW (IW)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .recover    (recover),
        .recover_id (recoverId),
        .head       (head_s),
        .occ        (occ_s)
    );

endmodule

// File: doc/ras_checkpointed.md
Name: ras_checkpointed

Overview:
Next-generation return address stack for the fetch unit. It is parametrised in depth, fetch width and checkpoint count, and computes the push address per slot. It keeps a circular checkpoint queue of (pointer, top entry, count), so the speculative stack can be repaired in one cycle when a branch resolves as mispredicted. It sits beside NextPC/Fetch: pops feed predicted targets, and the backend drives commit and recovery.

Parameters:
ENTRY_NUM, 16, stack depth (power of two, >=2)
FETCH_WIDTH, 4, instruction slots per fetch group
CKPT_NUM, 8, checkpoint queue depth (power of two, >=2)
PC_WIDTH, 32, address width
INSN_BYTES, 4, bytes per instruction

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (asserted at 0)
fetchValid  in  1  fetch group presented this cycle
groupPC  in  PC_WIDTH  PC of slot 0
isPush  in  FETCH_WIDTH  per-slot call flag
isPop  in  FETCH_WIDTH  per-slot return flag
popValid  out  1  popTarget valid (combinational)
popTarget  out  PC_WIDTH  predicted return address (combinational)
popSlot  out  log2(FETCH_WIDTH)  slot that popped
ckptFull  out  1  checkpoint queue full; fetch must stall
ckptId  out  log2(CKPT_NUM)  checkpoint id taken by this group's RAS op
commit  in  1  release oldest checkpoint
recover  in  1  restore to checkpoint recoverId
recoverId  in  log2(CKPT_NUM)  checkpoint to restore
recoverPush  in  1  after restore, push recoverPushPC
recoverPushPC  in  PC_WIDTH  correct return address of the mispredicted call
recoverPop  in  1  after restore, pop one entry

Behaviour:
- Reset (rst=0, async): all stack entries, ptr, count, ckpt head/tail/occupancy cleared. Outputs popValid=0, popTarget=0, popSlot=0, ckptFull=0, ckptId=0.
- Slot scan: lowest slot i with isPush[i] or isPop[i] is the group's only RAS op; push wins if both are set in the same slot. Later slots are ignored.
- Op accepted when fetchValid && !recover && !ckptFull && an op exists.
- Checkpoint: each accepted op first writes {ptr, stack[ptr], count} into ckpt[tail]. ckptId=tail (combinational). tail++ and occupancy++ on the edge.
- Push: next ptr = ptr+1 (mod ENTRY_NUM); stack[ptr+1] = groupPC + (i+1)*INSN_BYTES, truncated to PC_WIDTH. count saturates at ENTRY_NUM. Overflow overwrites the oldest entry silently.
- Pop: popValid=1 only if count>0; then popTarget=stack[ptr], popSlot=i, next ptr = ptr-1 and count-- on the edge. If count==0, popValid=0, ptr and count are unchanged, and a checkpoint is still allocated.
- Outputs are zero when no op is accepted; popValid=0 during recover or ckptFull.
- commit: head++, occupancy-- when occupancy>0; ignored when empty. A commit in the same cycle as an allocation leaves occupancy unchanged.
- recover (priority over fetch and commit): ptr, stack[saved ptr] and count are restored from ckpt[recoverId]. tail=recoverId+1, so younger checkpoints are discarded. Occupancy = (recoverId-head mod CKPT_NUM)+1. Then the optional correction is applied to the restored state:
  - recoverPush: ptr+1, write recoverPushPC, count saturates.
  - recoverPop: ptr-1, count-- if >0.
  - Both set: push wins.
  - All of this completes in one cycle; the next cycle sees the corrected stack.
- recoverId outside the live window is illegal; an assertion flags it and behaviour is undefined.
- ckptFull = (occupancy==CKPT_NUM), registered-state derived. A commit in the same cycle does not unblock it.
- Pointer and index arithmetic wraps modulo the power-of-two depth. The count register is log2(ENTRY_NUM)+1 bits wide.

Decomposition:
- Package FetchUnitTypes gains:
  - RAS_CKPT_ENTRY_NUM and RAS_CkptIndexPath
  - RAS_CheckpointEntry struct {ptr, top, count}
  - RAS_CountPath
- One sub-module, ras_checkpoint_queue: circular buffer holding alloc/commit/recover pointers, occupancy and full.
- Stack array, slot scan and correction logic stay in ras_checkpointed.

Test Plan:
- Reset then push at slot 2, groupPC=0x1000 -> stack top=0x100C, count=1, ckptId=0. Next cycle pop at slot 0 -> popValid=1, popTarget=0x100C, popSlot=0, count=0.
- Pop with empty stack -> popValid=0, ptr unchanged, checkpoint still allocated (ckptId increments).
- ENTRY_NUM=16: 17 pushes of 0x2000+16k, then 17 pops -> first 16 pops return 0x2100 down to 0x2010, count saturates at 16; 17th pop has popValid=0.
- Push A=0x3004, push B=0x4004 (ckpt 1), pop (ckpt 2) corrupting the top, then recover recoverId=1 with recoverPush PC=0x5004 -> next pop returns 0x5004, following pop returns 0x3004.
- Fill 8 checkpoints without commit -> ckptFull=1, the 9th op is not accepted (outputs 0). One commit -> ckptFull=0 the next cycle.
- recover and fetch push in the same cycle -> fetch ignored, no checkpoint allocated, only the restored state is visible. Async reset asserted mid-sequence -> all state cleared immediately.
